// File: rtl/lsu_pkg.sv
// Shared encodings and helpers for the data memory load/store unit.
// Sizes, FSM states and the request legality check live here.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_BAD  = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    WRITE,
    RESP
  } state_e;

  // An illegal size is reported the same way as a misaligned access.
  function automatic logic misaligned(
    input logic [1:0] size,
    input logic [1:0] off
  );
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_HALF: bad = off[0];
      SZ_WORD: bad = |off;
      SZ_BAD:  bad = 1'b1;
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_lane_unit.sv
// Little-endian lane logic: load extract/extend and sub-word store merge.
// Purely combinational; the FSM feeds it latched request fields.
module lsu_lane_unit
  import lsu_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  lane_i,
  input  logic        signed_i,
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] store_o
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b       = word_i[{lane_i, 3'b000} +: 8];
    h       = lane_i[1] ? word_i[31:16] : word_i[15:0];
    load_o  = word_i;
    store_o = wdata_i;
    unique case (1'b1)
      size_i == SZ_BYTE: begin
        load_o  = {{24{signed_i & b[7]}}, b};
        store_o = word_i;
        store_o[{lane_i, 3'b000} +: 8] = wdata_i[7:0];
      end
      size_i == SZ_HALF: begin
        load_o  = {{16{signed_i & h[15]}}, h};
        store_o = word_i;
        store_o[{lane_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/data_mem_lsu.sv
// Single-outstanding load/store requester in front of Data_mem.
// Sub-word stores are done as read-modify-write of the whole word.
module data_mem_lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Req_valid,
  output logic              Req_ready,
  input  logic              Req_we,
  input  logic [1:0]        Req_size,
  input  logic              Req_signed,
  input  logic [ADDR_W-1:0] Req_addr,
  input  logic [DATA_W-1:0] Req_wdata,
  output logic              Rsp_valid,
  output logic [DATA_W-1:0] Rsp_rdata,
  output logic              Rsp_err,
  output logic [ADDR_W-1:0] Mem_address,
  output logic [DATA_W-1:0] Mem_data_in,
  output logic              Mem_we,
  input  logic [DATA_W-1:0] Mem_data_out
);

  state_e state_q, state_d;

  logic [3:0]        cnt_q;
  logic              we_q;
  logic              sgn_q;
  logic              err_q;
  logic [1:0]        size_q;
  logic [1:0]        lane_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] mdin_q;
  logic [ADDR_W-1:0] maddr_q;
  logic [DATA_W-1:0] ld_data;
  logic [DATA_W-1:0] st_data;
  logic              bad;
  logic              rd_done;
  logic              wword;

  assign bad     = misaligned(Req_size, Req_addr[1:0]);
  assign wword   = Req_we && (Req_size == SZ_WORD);
  assign rd_done = cnt_q == 4'(RD_LAT);

  lsu_lane_unit u_lane (
    .size_i   (size_q),
    .lane_i   (lane_q),
    .signed_i (sgn_q),
    .word_i   (Mem_data_out),
    .wdata_i  (wdata_q),
    .load_o   (ld_data),
    .store_o  (st_data)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (Req_valid) begin
          if (bad)        state_d = RESP;
          else if (wword) state_d = WRITE;
          else            state_d = RD_WAIT;
        end
      end
      RD_WAIT: if (rd_done) state_d = we_q ? WRITE : RESP;
      WRITE:   state_d = RESP;
      RESP:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      sgn_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= '0;
      lane_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      mdin_q  <= '0;
      maddr_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && Req_valid) begin
        we_q    <= Req_we;
        sgn_q   <= Req_signed;
        size_q  <= Req_size;
        lane_q  <= Req_addr[1:0];
        wdata_q <= Req_wdata;
        err_q   <= bad;
        rdata_q <= '0;
        cnt_q   <= '0;
        if (!bad) maddr_q <= {Req_addr[ADDR_W-1:2], 2'b00};
        if (!bad && wword) mdin_q <= Req_wdata;
      end
      // The word captured here is either the load source or the RMW base.
      if (state_q == RD_WAIT) begin
        if (rd_done) begin
          if (we_q) mdin_q  <= st_data;
          else      rdata_q <= ld_data;
        end else begin
          cnt_q <= cnt_q + 4'd1;
        end
      end
    end
  end

  assign Req_ready   = Rst_n && (state_q == IDLE);
  assign Rsp_valid   = state_q == RESP;
  assign Rsp_rdata   = rdata_q;
  assign Rsp_err     = err_q;
  assign Mem_address = maddr_q;
  assign Mem_data_in = mdin_q;
  assign Mem_we      = state_q == WRITE;

endmodule

// File: tb/tb_data_mem_lsu.sv
// Randomized bench for data_mem_lsu against a word-array reference model.
// Includes a registered-read Data_mem stand-in with one cycle of latency.
module tb_data_mem_lsu;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        Req_valid = 1'b0;
  logic        Req_ready;
  logic        Req_we = 1'b0;
  logic [1:0]  Req_size = 2'b00;
  logic        Req_signed = 1'b0;
  logic [31:0] Req_addr = '0;
  logic [31:0] Req_wdata = '0;
  logic        Rsp_valid;
  logic [31:0] Rsp_rdata;
  logic        Rsp_err;
  logic [31:0] Mem_address;
  logic [31:0] Mem_data_in;
  logic        Mem_we;
  logic [31:0] Mem_data_out;

  always #5 Clk = ~Clk;

  data_mem_lsu dut (
    .Clk          (Clk),
    .Rst_n        (Rst_n),
    .Req_valid    (Req_valid),
    .Req_ready    (Req_ready),
    .Req_we       (Req_we),
    .Req_size     (Req_size),
    .Req_signed   (Req_signed),
    .Req_addr     (Req_addr),
    .Req_wdata    (Req_wdata),
    .Rsp_valid    (Rsp_valid),
    .Rsp_rdata    (Rsp_rdata),
    .Rsp_err      (Rsp_err),
    .Mem_address  (Mem_address),
    .Mem_data_in  (Mem_data_in),
    .Mem_we       (Mem_we),
    .Mem_data_out (Mem_data_out)
  );

  logic [31:0] dmem [64];
  logic [31:0] ref_mem [64];
  logic [31:0] rdout;

  always @(posedge Clk) begin
    if (Mem_we) dmem[Mem_address[7:2]] <= Mem_data_in;
    rdout <= dmem[Mem_address[7:2]];
  end
  assign Mem_data_out = rdout;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct { int c; logic [31:0] d; logic e; } rsp_t;
  typedef struct { int c; logic [31:0] a; logic [31:0] d; } wr_t;
  rsp_t rq[$];
  wr_t  wq[$];

  int total = 0;
  int fails = 0;
  int last_a = -1000;
  int last_lat = 0;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  always @(negedge Clk) begin : compare
    logic exp_rdy;
    rsp_t r;
    wr_t  w;
    exp_rdy = Rst_n && !(cyc >= last_a && cyc <= last_a + last_lat);
    chk("req_ready", {31'b0, Req_ready}, {31'b0, exp_rdy});
    if (Rsp_valid) begin
      if (rq.size() == 0) begin
        chk("rsp_valid_unexpected", {31'b0, Rsp_valid}, 32'd0);
      end else begin
        r = rq.pop_front();
        chk("rsp_cycle", 32'(cyc), 32'(r.c));
        chk("rsp_rdata", Rsp_rdata, r.d);
        chk("rsp_err", {31'b0, Rsp_err}, {31'b0, r.e});
      end
    end else if (rq.size() > 0 && rq[0].c <= cyc) begin
      chk("rsp_valid_missing", {31'b0, Rsp_valid}, 32'd1);
      void'(rq.pop_front());
    end
    if (Mem_we) begin
      if (wq.size() == 0) begin
        chk("mem_we_unexpected", {31'b0, Mem_we}, 32'd0);
      end else begin
        w = wq.pop_front();
        chk("wr_cycle", 32'(cyc), 32'(w.c));
        chk("wr_addr", Mem_address, w.a);
        chk("wr_data", Mem_data_in, w.d);
      end
    end else if (wq.size() > 0 && wq[0].c <= cyc) begin
      chk("mem_we_missing", {31'b0, Mem_we}, 32'd1);
      void'(wq.pop_front());
    end
  end

  task automatic garble();
    Req_we     = 1'($urandom);
    Req_size   = 2'($urandom);
    Req_signed = 1'($urandom);
    Req_addr   = $urandom;
    Req_wdata  = $urandom;
  endtask

  task automatic do_req(input bit we, input logic [1:0] sz, input bit sg,
                        input logic [31:0] ad, input logic [31:0] wd,
                        input bit b2b, input bit abort,
                        output logic [31:0] er, output logic ee);
    int idx;
    int sh;
    int lat;
    int a;
    bit bad;
    bit got;
    logic [31:0] w;
    logic [31:0] rd;
    logic [31:0] mask;
    logic [31:0] nw;
    idx  = int'(ad[7:2]);
    bad  = (sz == 2'd3) || (sz == 2'd1 && ad[0]) ||
           (sz == 2'd2 && ad[1:0] != 2'd0);
    sh   = (sz == 2'd1) ? 16 * int'(ad[1]) : 8 * int'(ad[1:0]);
    w    = ref_mem[idx];
    rd   = 32'd0;
    nw   = w;
    mask = (sz == 2'd0) ? (32'hFF << sh) :
           (sz == 2'd1) ? (32'hFFFF << sh) : 32'hFFFF_FFFF;
    if (bad) begin
      lat = 0;
    end else if (!we) begin
      lat = 2;
      rd  = (w >> sh) & mask >> sh;
      if (sz == 2'd0 && sg && rd[7])  rd = rd | 32'hFFFF_FF00;
      if (sz == 2'd1 && sg && rd[15]) rd = rd | 32'hFFFF_0000;
    end else begin
      lat = (sz == 2'd2) ? 1 : 3;
      nw  = (w & ~mask) | ((wd << sh) & mask);
    end
    er  = rd;
    ee  = bad;
    got = 0;
    for (int n = 0; n < 100 && !got; n++) begin
      @(negedge Clk);
      if (Req_ready) got = 1;
      else if (Req_valid) garble();
    end
    if (!got) begin
      chk("accept_timeout", {31'b0, Req_ready}, 32'd1);
      return;
    end
    Req_valid  = 1'b1;
    Req_we     = we;
    Req_size   = sz;
    Req_signed = sg;
    Req_addr   = ad;
    Req_wdata  = wd;
    a          = cyc + 1;
    last_a     = a;
    last_lat   = lat;
    if (!abort) begin
      rq.push_back('{c: a + lat, d: rd, e: bad});
      if (!bad && we) begin
        wq.push_back('{c: a + ((sz == 2'd2) ? 0 : 2),
                       a: {ad[31:2], 2'b00}, d: nw});
        ref_mem[idx] = nw;
      end
    end
    @(posedge Clk);
    #1;
    Req_valid = b2b;
    if (b2b) garble();
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [31:0] r;
    logic        e;
    logic [31:0] v;
    logic [31:0] ad;
    logic [1:0]  sz;
    for (int i = 0; i < 64; i++) begin
      v = $urandom;
      dmem[i] = v;
      ref_mem[i] = v;
    end
    dmem[4]  = 32'h1122_3344; ref_mem[4]  = 32'h1122_3344;
    dmem[8]  = 32'h80F0_7F01; ref_mem[8]  = 32'h80F0_7F01;
    dmem[12] = 32'h0BAD_F00D; ref_mem[12] = 32'h0BAD_F00D;

    @(negedge Clk);
    #1;
    chk("rst_mem_we", {31'b0, Mem_we}, 32'd0);
    chk("rst_rsp_valid", {31'b0, Rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", Rsp_rdata, 32'd0);
    chk("rst_mem_address", Mem_address, 32'd0);
    chk("rst_mem_data_in", Mem_data_in, 32'd0);
    @(negedge Clk);
    #2 Rst_n = 1'b1;

    do_req(1, 2'd2, 0, 32'h40, 32'hDEAD_BEEF, 0, 0, r, e);
    do_req(0, 2'd2, 0, 32'h40, 32'h0, 0, 0, r, e);
    chk("model_word_load", r, 32'hDEAD_BEEF);
    do_req(1, 2'd0, 0, 32'h12, 32'h0000_00AA, 0, 0, r, e);
    do_req(0, 2'd2, 0, 32'h10, 32'h0, 0, 0, r, e);
    chk("model_byte_merge", r, 32'h11AA_3344);
    do_req(0, 2'd0, 1, 32'h23, 32'h0, 0, 0, r, e);
    chk("model_sbyte", r, 32'hFFFF_FF80);
    do_req(0, 2'd0, 0, 32'h22, 32'h0, 0, 0, r, e);
    chk("model_ubyte", r, 32'h0000_00F0);
    do_req(0, 2'd1, 1, 32'h20, 32'h0, 0, 0, r, e);
    chk("model_shalf", r, 32'h0000_7F01);
    do_req(0, 2'd1, 1, 32'h22, 32'h0, 0, 0, r, e);
    chk("model_shalf_hi", r, 32'hFFFF_80F0);
    do_req(0, 2'd2, 0, 32'h42, 32'h0, 0, 0, r, e);
    chk("model_err_word", {31'b0, e}, 32'd1);
    do_req(1, 2'd1, 0, 32'h31, 32'hBEEF, 0, 0, r, e);
    chk("model_err_half", {31'b0, e}, 32'd1);
    do_req(0, 2'd3, 0, 32'h50, 32'h0, 0, 0, r, e);
    chk("model_err_size", {31'b0, e}, 32'd1);

    for (int i = 0; i < 8; i++) begin
      sz = 2'($urandom_range(0, 2));
      ad = {24'h0, 8'($urandom)};
      if (sz == 2'd1) ad[0] = 1'b0;
      if (sz == 2'd2) ad[1:0] = 2'b00;
      do_req(1'($urandom), sz, 1'($urandom), ad, $urandom, i < 7, 0, r, e);
    end

    do_req(1, 2'd0, 0, 32'h31, 32'h77, 0, 1, r, e);
    @(negedge Clk);
    #2 Rst_n = 1'b0;
    #1 chk("abort_mem_we", {31'b0, Mem_we}, 32'd0);
    repeat (2) @(negedge Clk);
    #2 Rst_n = 1'b1;
    last_a = -1000;
    do_req(0, 2'd2, 0, 32'h30, 32'h0, 0, 0, r, e);
    chk("model_after_abort", r, 32'h0BAD_F00D);

    for (int i = 0; i < 200; i++) begin
      sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      ad = {8'($urandom), 16'h0, 8'($urandom)};
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) ad[0] = 1'b0;
        if (sz == 2'd2) ad[1:0] = 2'b00;
      end
      do_req(1'($urandom), sz, 1'($urandom), ad, $urandom,
             (i < 199) && 1'($urandom), 0, r, e);
    end

    repeat (8) @(negedge Clk);
    chk("rsp_queue_drained", 32'(rq.size()), 32'd0);
    chk("wr_queue_drained", 32'(wq.size()), 32'd0);
    for (int i = 0; i < 64; i++) chk("final_mem", dmem[i], ref_mem[i]);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule

// File: doc/data_mem_lsu.md
Name: data_mem_lsu

Overview:
Load/store requester that sits between the CPU datapath and the Data_mem block, and drives Data_mem's address, data-in and write-enable interface. It accepts one load or store at a time over a valid/ready handshake. It performs byte and halfword stores by read-modify-write of the 32-bit word, and returns load data extracted, zero- or sign-extended, with a one-cycle response pulse.

Parameters:
ADDR_W, 32, request and memory address width
DATA_W, 32, memory word width (fixed at 32; byte/half lane logic depends on it)
RD_LAT, 1, edges from Mem_address being driven to Mem_data_out being valid for capture

Ports:
Clk  in  1  system clock, rising edge
Rst_n  in  1  asynchronous active-low reset
Req_valid  in  1  request present
Req_ready  out  1  LSU can accept a request
Req_we  in  1  1 = store, 0 = load
Req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
Req_signed  in  1  sign-extend sub-word loads
Req_addr  in  ADDR_W  byte address
Req_wdata  in  DATA_W  store data, right-aligned
Rsp_valid  out  1  one-cycle completion pulse
Rsp_rdata  out  DATA_W  load result (0 for stores and errors)
Rsp_err  out  1  misaligned or illegal request
Mem_address  out  ADDR_W  word-aligned address to Data_mem (bits [1:0] = 0)
Mem_data_in  out  DATA_W  write data to Data_mem
Mem_we  out  1  Data_mem write enable
Mem_data_out  in  DATA_W  read data from Data_mem

Behaviour:
- Reset (Rst_n low, async): state IDLE; all registered outputs 0; Mem_we forced 0 immediately; Req_ready 0 while Rst_n is low, 1 once in IDLE.
- Accept: Req_valid && Req_ready at edge E0; latch all Req_* fields. Req_ready = (state == IDLE) only; no request queueing.
- States: IDLE, RD_WAIT, WRITE, RESP.
- Error check at accept: size 11, half with addr[0]=1, or word with addr[1:0]!=0 -> go to RESP with Rsp_err=1 and Rsp_rdata=0. No memory access; Mem_we stays 0.
- Load: IDLE -> RD_WAIT; Mem_address driven from E0; Mem_data_out captured RD_LAT+1 edges after E0 (E2 at default); -> RESP.
- Load extraction is little-endian: byte lane = addr[1:0], half lane = addr[1]. Zero- or sign-extend per the latched Req_signed. Word loads ignore Req_signed.
- Word store: IDLE -> WRITE; Mem_we=1 and Mem_data_in=wdata for exactly the cycle E0–E1; -> RESP.
- Byte/half store: IDLE -> RD_WAIT (read of the target word) -> WRITE.
  - Merge replaces only the addressed lane with wdata[7:0] or wdata[15:0]; other lanes come from the captured word.
  - Mem_we=1 for one cycle -> RESP.
- RESP: Rsp_valid=1 for exactly one cycle; Req_ready=0; next edge -> IDLE. There is no response backpressure.
- Latency at RD_LAT=1:
  - load: Rsp_valid in cycle E2–E3
  - word store: Rsp_valid in cycle E1–E2
  - sub-word store: Mem_we in E2–E3, Rsp_valid in E3–E4
  - error: Rsp_valid in E0–E1
- Mem_address holds its value until the next accept. Mem_data_in is don't-care when Mem_we=0 but is held stable.
- Rst_n asserted mid-operation: abort, no response, and no write issued afterwards. A write cycle already in progress is cut off by the async deassert of Mem_we.
- Address bits above [1:0] pass through unchanged; no range checking is done here.

Decomposition:
- Shared package (lsu_pkg):
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD/SZ_BAD
  - state enum
  - function misaligned(size, addr)
- Sub-module lsu_lane_unit: combinational load extract/extend and store merge, given size, addr[1:0], signed, word and wdata. The FSM and registers stay in data_mem_lsu.

Test Plan:
- Word store then load: store 0xDEADBEEF @0x40 -> Mem_we pulses 1 cycle with Mem_address=0x40; load @0x40 -> Rsp_rdata=0xDEADBEEF, Rsp_valid 2 cycles after accept.
- Byte store merge: memory 0x11223344 @0x10; store byte 0xAA @0x12 -> memory becomes 0x11AA3344, Mem_we exactly one cycle, Rsp_valid 3 cycles after accept.
- Sign/zero extension: memory 0x80F07F01 @0x20; signed byte load @0x23 -> 0xFFFFFF80; unsigned byte @0x22 -> 0x000000F0; signed half @0x20 -> 0x00007F01.
- Misalignment: word load @0x42, half store @0x31, size 11 -> each gives Rsp_err=1, Rsp_rdata=0, Rsp_valid the cycle after accept, Mem_we never asserted, memory unchanged.
- Handshake: Req_valid held high across back-to-back requests -> Req_ready low from accept until after Rsp_valid; each request is accepted exactly once; changing Req_* while busy has no effect.
- Reset mid sub-word store: pull Rst_n low during RD_WAIT -> Mem_we stays 0, no Rsp_valid, memory unchanged; after release Req_ready=1 and a new load completes normally.
